cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Parametrised N-requester arbiter in front of the single scalar/vector data-cache port of the core. Round-robin grants, one outstanding access at a time, stall on `miss_cache`, registered response to the granted requester. Sits between the pipeline's memory users (load/store unit, vector unit, loader) and the cache.

## Interface
- `NUM_PORTS`, 2: requester count, 2..8.
- `LANES`, 4: vector lanes of 32 bits; vector data width is 32*LANES.
- `clk`  in  1  core clock.
- `rstn`  in  1  asynchronous active-low reset.
- `req`  in  NUM_PORTS  per-port request; held with payload until `gnt` bit seen.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_vec`  in  NUM_PORTS  1 = vector access.
- `req_addr`  in  32*NUM_PORTS  port i at [32i+31:32i].
- `req_wdata`  in  32*NUM_PORTS  scalar write data.
- `req_vec_wdata`  in  32*LANES*NUM_PORTS  vector write data.
- `req_vec_mask`  in  LANES*NUM_PORTS  lane enables.
- `gnt`  out  NUM_PORTS  one-hot, one-cycle pulse on capture.
- `resp_valid`  out  NUM_PORTS  one-hot, one-cycle pulse on completion (reads and writes).
- `resp_rdata`  out  32  scalar read data, valid with `resp_valid`.
- `resp_vec_rdata`  out  32*LANES  vector read data, valid with `resp_valid`.
- `addr_cache`, `wdata_cache`  out  32 each; `rdata_cache`  in  32.
- `write_enable_cache`, `read_enable_cache`  out  1; `miss_cache`  in  1.
- `vec_wdata_cache`  out  32*LANES; `vec_rdata_cache`  in  32*LANES.
- `vec_mode_cache`  out  1; `vec_mask_cache`  out  LANES.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any `req`, select first requesting port at or after pointer `rr` (wrapping modulo NUM_PORTS); register its payload and index; pulse its `gnt`; go BUSY. No request: stay.
- BUSY: drive cache outputs from registers; exactly one of `read_enable_cache`/`write_enable_cache` high. `miss_cache`=1: hold all outputs, stay. `miss_cache`=0: access completes this cycle; register `rdata_cache`/`vec_rdata_cache` (zeros for writes); `rr` <= index+1 mod NUM_PORTS; go RESP.
- RESP: pulse `resp_valid` of owner; drop cache enables; go IDLE. New arbitration begins next cycle (no back-to-back grant from RESP).
- Requests arriving while BUSY/RESP are ignored until IDLE; requester keeps `req` high.
- `req_vec`=1 sets `vec_mode_cache`=1 and forwards mask; scalar access drives `vec_mode_cache`=0, mask 0.
- Port whose `req` drops before grant is simply not selected; no error.

## Timing
- Reset (async assert, sync release): state IDLE, `rr`=0, all outputs 0 including `gnt`, `resp_valid`, data and enables. Reset during BUSY abandons the access; no response issued.
- Request seen in IDLE cycle t: `gnt` and cache enable high cycle t+1; with no miss, `resp_valid` high cycle t+2. Each miss cycle adds one.
- Throughput: one access per 3 cycles minimum.
- Cache outputs stable for the whole BUSY interval; `addr_cache` etc. change only on IDLE->BUSY capture.
- Simultaneous requests: port chosen by round-robin; priority after reset is port 0 highest.
- `miss_cache` outside BUSY is ignored.

## Configuration
- `CACHE_ARB_VEC_EN` defined: vector path present as above.
- Undefined: `req_vec`, `req_vec_wdata`, `req_vec_mask`, `vec_rdata_cache` ignored; vector requests executed as scalar accesses; `vec_mode_cache`, `vec_mask_cache`, `vec_wdata_cache`, `resp_vec_rdata` constant 0. Port list unchanged.

## Test plan
- Reset: `rstn`=0 mid-BUSY with miss high -> all outputs 0 next sample, no `resp_valid`; after release first request granted to port 0 priority.
- Single read, port 1, addr 0x100, cache returns 0xDEADBEEF, no miss -> `gnt`=2'b10 at t+1, `read_enable_cache`=1 at t+1, `resp_valid`=2'b10 with `resp_rdata`=0xDEADBEEF at t+2.
- Write with 3 miss cycles, port 0, addr 0x40, data 0x12345678 -> `write_enable_cache` held 4 cycles with stable addr/data, `resp_valid`=2'b01 at t+5, `resp_rdata`=0.
- Both ports request continuously (NUM_PORTS=2) -> grants alternate 0,1,0,1 every 3 cycles.
- Vector read port 0, mask 4'b0101, `vec_rdata_cache`=128'h0123..CDEF -> `vec_mode_cache`=1, `vec_mask_cache`=4'b0101, `resp_vec_rdata` equals input; without `CACHE_ARB_VEC_EN` -> `vec_mode_cache`=0, `resp_vec_rdata`=0.
- NUM_PORTS=4, ports 1 and 3 request after port 3 was last served -> port 1 granted first (pointer wraps to 0).

Source files
------------

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Round-robin arbiter that shares the single scalar/vector data-cache port
//   between NUM_PORTS requesters. It runs one access at a time through
//   IDLE -> BUSY -> RESP. In BUSY it waits out cache misses. In RESP it
//   returns a registered one-cycle response to the port that owned the access.
//
//   Optional feature macro: CACHE_ARB_VEC_EN
//     defined   : the vector path is live (vec_mode/mask/wdata/rdata).
//     undefined : vector inputs are ignored and vector requests run as scalar
//                 accesses. All vector outputs are tied to 0, and the port
//                 list is the same in both builds.
//
// Handshake: a requester raises req[i] with a stable payload and holds both
//   until it sees its gnt[i] pulse. The arbiter copies the payload into
//   registers in the same clock edge that raises gnt. After that edge the
//   requester may drop or change req. resp_valid[i] later pulses for one
//   cycle, and resp_rdata / resp_vec_rdata are valid in that cycle.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset. Reset
//                             release is expected to be synchronised upstream.
//   req/req_we/req_vec        per-port request, write flag, vector flag
//   req_addr/req_wdata        per-port 32-bit address / scalar write data
//   req_vec_wdata/req_vec_mask per-port vector write data / lane enables
//   gnt, resp_valid           one-hot, one-cycle pulses
//   resp_rdata/resp_vec_rdata registered read data returned to the owner
//   *_cache                   cache-side interface
//   dbg_state                 current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module cache_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int LANES     = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS-1:0]          req_vec,
    input  logic [32*NUM_PORTS-1:0]       req_addr,
    input  logic [32*NUM_PORTS-1:0]       req_wdata,
    input  logic [32*LANES*NUM_PORTS-1:0] req_vec_wdata,
    input  logic [LANES*NUM_PORTS-1:0]    req_vec_mask,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [31:0]                   resp_rdata,
    output logic [32*LANES-1:0]           resp_vec_rdata,
    output logic [31:0]                   addr_cache,
    output logic [31:0]                   wdata_cache,
    input  logic [31:0]                   rdata_cache,
    output logic                          write_enable_cache,
    output logic                          read_enable_cache,
    input  logic                          miss_cache,
    output logic [32*LANES-1:0]           vec_wdata_cache,
    input  logic [32*LANES-1:0]           vec_rdata_cache,
    output logic                          vec_mode_cache,
    output logic [LANES-1:0]              vec_mask_cache,
    output logic [1:0]                    dbg_state
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int CW    = IDX_W + 1;  // one spare bit so rr + offset cannot overflow

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state, w_next_state;
    logic                   w_capture, w_complete;
    logic                   w_found;
    logic [IDX_W-1:0]       w_sel;
    logic [CW-1:0]          w_cand;
    logic [CW-1:0]          w_rr_inc;
    logic [IDX_W-1:0]       w_rr_next;

    logic [IDX_W-1:0]       r_rr;
    logic [IDX_W-1:0]       r_owner;
    logic [NUM_PORTS-1:0]   r_gnt;
    logic [NUM_PORTS-1:0]   r_resp_valid;
    logic                   r_we;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;

    localparam logic [NUM_PORTS-1:0] ONE_HOT_0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    // Search starts at the pointer and wraps, so the first port found is the
    // first requester at or after rr.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, r_rr} + CW'(k);
            if (w_cand >= CW'(NUM_PORTS)) begin
                w_cand = w_cand - CW'(NUM_PORTS);
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[IDX_W-1:0];
            end
        end
    end

    // After an access completes, the port just served gets lowest priority.
    always_comb begin
        w_rr_inc  = {1'b0, r_owner} + CW'(1);
        w_rr_next = w_rr_inc[IDX_W-1:0];
        if (w_rr_inc >= CW'(NUM_PORTS)) begin
            w_rr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_BUSY;
                    w_capture    = 1'b1;
                end
            end
            S_BUSY: begin
                // A miss holds every cache-side output as it is.
                if (!miss_cache) begin
                    w_next_state = S_RESP;
                    w_complete   = 1'b1;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr         <= '0;
            r_owner      <= '0;
            r_gnt        <= '0;
            r_resp_valid <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            r_gnt        <= '0;
            r_resp_valid <= '0;
            if (w_capture) begin
                r_owner <= w_sel;
                r_gnt   <= ONE_HOT_0 << w_sel;
                r_we    <= req_we[w_sel];
                r_addr  <= req_addr[32*w_sel +: 32];
                r_wdata <= req_wdata[32*w_sel +: 32];
            end
            if (w_complete) begin
                r_rr         <= w_rr_next;
                r_resp_valid <= ONE_HOT_0 << r_owner;
                r_rdata      <= r_we ? 32'h0 : rdata_cache;
            end
        end
    end

`ifdef CACHE_ARB_VEC_EN
    logic                r_vec;
    logic [LANES-1:0]    r_vec_mask;
    logic [32*LANES-1:0] r_vec_wdata;
    logic [32*LANES-1:0] r_vec_rdata;

    // Scalar accesses clear the vector registers so mask and data read as 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vec       <= 1'b0;
            r_vec_mask  <= '0;
            r_vec_wdata <= '0;
            r_vec_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_vec       <= req_vec[w_sel];
                r_vec_mask  <= req_vec[w_sel] ? req_vec_mask[LANES*w_sel +: LANES] : '0;
                r_vec_wdata <= req_vec[w_sel] ? req_vec_wdata[32*LANES*w_sel +: 32*LANES] : '0;
            end
            if (w_complete) begin
                r_vec_rdata <= (r_we || !r_vec) ? '0 : vec_rdata_cache;
            end
        end
    end

    assign vec_mode_cache  = r_vec;
    assign vec_mask_cache  = r_vec_mask;
    assign vec_wdata_cache = r_vec_wdata;
    assign resp_vec_rdata  = r_vec_rdata;
`else
    // The vector inputs are not used in this build. They are reduced into one
    // unused net so that the port list can stay the same in both builds.
    logic w_unused_vec;
    assign w_unused_vec    = ^{req_vec, req_vec_wdata, req_vec_mask, vec_rdata_cache};
    assign vec_mode_cache  = 1'b0;
    assign vec_mask_cache  = '0;
    assign vec_wdata_cache = '0;
    assign resp_vec_rdata  = '0;
`endif

    // The enables are decoded from the state register. They are high for the
    // whole of BUSY and low in every other state.
    assign read_enable_cache  = (r_state == S_BUSY) && !r_we;
    assign write_enable_cache = (r_state == S_BUSY) && r_we;
    assign addr_cache         = r_addr;
    assign wdata_cache        = r_wdata;
    assign gnt                = r_gnt;
    assign resp_valid         = r_resp_valid;
    assign resp_rdata         = r_rdata;
    assign dbg_state          = r_state;

endmodule
